// File: rtl/sp_arb_pkg.sv
// sp_arb_pkg: shared constants, width helper and read-pipeline entry type for the SRAM arbiter
package sp_arb_pkg;
  localparam int PRIO_RR = 0;
  localparam int PRIO_FIXED = 1;
  localparam int CH_ID_W = 3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
  typedef struct packed {
    logic valid;
    logic [CH_ID_W-1:0] ch_id;
  } rd_ent_t;
endpackage

// File: rtl/sp_rr_picker.sv
// sp_rr_picker: one-hot rotate-priority picker, search starts at start (or 0 in fixed mode)
module sp_rr_picker #(
  parameter int NUM_CH = 2,
  parameter int ID_W = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   start,
  input  logic              mode,
  output logic [NUM_CH-1:0] win
);
  int base;
  logic [NUM_CH-1:0] cand;
  always_comb begin
    base = mode ? 0 : int'(start);
    win = '0;
    cand = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = NUM_CH'(1) << ((base + i) % NUM_CH);
      if (|(req & cand)) win = cand;
    end
  end
endmodule

// File: rtl/sp_sram_arbiter.sv
// sp_sram_arbiter: N-channel single-port SRAM arbiter with RR/fixed priority, bounded lock and read return
module sp_sram_arbiter
  import sp_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int PRIO_MODE = 0,
  parameter int MAX_LOCK = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  input  logic [NUM_CH-1:0]        lock,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        sram_ADDR,
  output logic [DATA_W-1:0]        sram_DI,
  output logic                     sram_EN,
  output logic                     sram_WE,
  input  logic [DATA_W-1:0]        sram_DO
);
  localparam int ID_W = clog2(NUM_CH);
  localparam int LC_W = clog2(MAX_LOCK + 1);
  logic [ID_W-1:0] last_winner, lock_own, start, win_id;
  logic [LC_W-1:0] lock_cnt;
  logic lock_act, lock_hit;
  logic [NUM_CH-1:0] pick;
  rd_ent_t pipe [RD_LAT];
  assign start = (int'(last_winner) == NUM_CH - 1) ? '0 : last_winner + ID_W'(1);
  assign lock_hit = lock_act && req[lock_own] && (lock_cnt < LC_W'(MAX_LOCK));
  sp_rr_picker #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_picker (
    .req(req),
    .start(start),
    .mode(PRIO_MODE == PRIO_FIXED),
    .win(pick)
  );
  always_comb begin
    gnt = reset ? '0 : lock_hit ? NUM_CH'(1) << lock_own : pick;
    win_id = '0;
    sram_WE = 1'b0;
    sram_ADDR = '0;
    sram_DI = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (gnt[i]) begin
        win_id = ID_W'(i);
        sram_WE = we[i];
        sram_ADDR = addr[i*ADDR_W +: ADDR_W];
        sram_DI = wdata[i*DATA_W +: DATA_W];
      end
    sram_EN = |(req & gnt);
  end
  assign rvalid = (!reset && pipe[RD_LAT-1].valid) ? NUM_CH'(1) << pipe[RD_LAT-1].ch_id : '0;
  assign rdata = sram_DO;
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner <= ID_W'(NUM_CH - 1);
      lock_own <= '0;
      lock_act <= 1'b0;
      lock_cnt <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      if (sram_EN) begin
        last_winner <= win_id;
        lock_own <= win_id;
        lock_act <= lock[win_id];
        lock_cnt <= lock_hit ? lock_cnt + LC_W'(1) : '0;
      end else begin
        lock_act <= 1'b0;
        lock_cnt <= '0;
      end
      pipe[0] <= '{valid: sram_EN & ~sram_WE, ch_id: CH_ID_W'(win_id)};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
endmodule

// File: tb/tb_sp_sram_arbiter.sv
// tb_sp_sram_arbiter: directed checks of a round-robin (RD_LAT=1) and a fixed-priority (RD_LAT=2) arbiter
module tb_sp_sram_arbiter;
  logic clk, reset;
  int checks, failures;
  logic [2:0] a_req, a_we, a_lock, a_gnt, a_rvalid;
  logic [47:0] a_addr;
  logic [95:0] a_wdata;
  logic [31:0] a_rdata, a_sdi, a_do;
  logic [15:0] a_sa;
  logic a_en, a_swe;
  logic [31:0] a_mem [256];
  logic [2:0] b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [47:0] b_addr;
  logic [95:0] b_wdata;
  logic [31:0] b_rdata, b_sdi, b_do, b_d1;
  logic [15:0] b_sa;
  logic b_en, b_swe;
  logic [31:0] b_mem [256];
  sp_sram_arbiter #(.NUM_CH(3), .ADDR_W(16), .DATA_W(32), .RD_LAT(1), .PRIO_MODE(0), .MAX_LOCK(4)) u_a (
    .clk(clk), .reset(reset), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata), .lock(a_lock),
    .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata), .sram_ADDR(a_sa), .sram_DI(a_sdi),
    .sram_EN(a_en), .sram_WE(a_swe), .sram_DO(a_do)
  );
  sp_sram_arbiter #(.NUM_CH(3), .ADDR_W(16), .DATA_W(32), .RD_LAT(2), .PRIO_MODE(1), .MAX_LOCK(4)) u_b (
    .clk(clk), .reset(reset), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata), .lock(b_lock),
    .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .sram_ADDR(b_sa), .sram_DI(b_sdi),
    .sram_EN(b_en), .sram_WE(b_swe), .sram_DO(b_do)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (reset)
      for (int i = 0; i < 256; i++) a_mem[i] <= {16'hA5A5, 8'h00, 8'(i)};
    else if (a_en) begin
      if (a_swe) a_mem[a_sa[7:0]] <= a_sdi;
      else a_do <= a_mem[a_sa[7:0]];
    end
  end
  always @(posedge clk) begin
    if (reset)
      for (int i = 0; i < 256; i++) b_mem[i] <= {16'hA5A5, 8'h00, 8'(i)};
    else if (b_en) begin
      if (b_swe) b_mem[b_sa[7:0]] <= b_sdi;
      else b_d1 <= b_mem[b_sa[7:0]];
    end
    b_do <= b_d1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    {a_req, a_we, a_lock, a_addr, a_wdata} = '0;
    {b_req, b_we, b_lock, b_addr, b_wdata} = '0;
    repeat (3) @(negedge clk);
    a_req = 3'b111;
    a_addr = {16'h0030, 16'h0020, 16'h0010};
    b_req = 3'b101;
    #1;
    check("rst_a_gnt", a_gnt, 0);
    check("rst_a_en", a_en, 0);
    check("rst_a_addr", a_sa, 0);
    check("rst_b_gnt", b_gnt, 0);
    check("rst_a_rvalid", a_rvalid, 0);
    @(negedge clk);
    reset = 1'b0;
    b_req = 3'b000;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("rr_gnt", a_gnt, 3'b001 << (k % 3));
      check("rr_addr", a_sa, 16'h10 * (k % 3 + 1));
      check("rr_rvalid", a_rvalid, (k == 0) ? 3'b000 : 3'b001 << (k - 1));
      if (k > 0) check("rr_rdata", a_rdata, 32'hA5A5_0000 | (32'h10 * k));
    end
    @(negedge clk);
    a_req = 3'b011;
    a_we = 3'b010;
    a_addr = {16'h0030, 16'h0040, 16'h0040};
    a_wdata = {32'h0, 32'hDEADBEEF, 32'h0};
    #1;
    check("rr_wrap_rvalid", a_rvalid, 3'b001);
    check("rr_wrap_rdata", a_rdata, 32'hA5A5_0010);
    check("ord_w_gnt", a_gnt, 3'b010);
    check("ord_w_we", a_swe, 1);
    check("ord_w_di", a_sdi, 32'hDEADBEEF);
    check("ord_w_addr", a_sa, 16'h0040);
    @(negedge clk);
    a_req = 3'b001;
    a_we = 3'b000;
    #1;
    check("ord_w_norv", a_rvalid, 3'b000);
    check("ord_r_gnt", a_gnt, 3'b001);
    check("ord_r_we", a_swe, 0);
    @(negedge clk);
    a_req = 3'b100;
    #1;
    check("ord_r_rvalid", a_rvalid, 3'b001);
    check("ord_r_rdata", a_rdata, 32'hDEADBEEF);
    check("pre_lock_gnt", a_gnt, 3'b100);
    @(negedge clk);
    a_req = 3'b011;
    a_lock = 3'b001;
    a_addr = {16'h0030, 16'h0020, 16'h0010};
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (k == 0) check("pre_lock_rdata", a_rdata, 32'hA5A5_0030);
      check("lock_gnt", a_gnt, (k == 5) ? 3'b010 : 3'b001);
    end
    @(negedge clk);
    a_req = 3'b000;
    a_lock = 3'b000;
    b_req = 3'b101;
    b_addr = {16'h0070, 16'h0022, 16'h0050};
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 3) b_req = 3'b100;
      #1;
      check("fx_gnt", b_gnt, (k == 3) ? 3'b100 : 3'b001);
      check("fx_rvalid", b_rvalid, (k >= 2) ? 3'b001 : 3'b000);
    end
    check("fx_rdata", b_rdata, 32'hA5A5_0050);
    @(negedge clk);
    b_req = 3'b010;
    #1;
    check("drop_gnt", b_gnt, 3'b010);
    @(negedge clk);
    b_req = 3'b000;
    #1;
    check("fx_ch2_rvalid", b_rvalid, 3'b100);
    check("fx_ch2_rdata", b_rdata, 32'hA5A5_0070);
    check("drop_gnt_idle", b_gnt, 3'b000);
    @(negedge clk);
    #1;
    check("drop_rvalid", b_rvalid, 3'b010);
    check("drop_rdata", b_rdata, 32'hA5A5_0022);
    @(negedge clk);
    #1;
    check("drop_once", b_rvalid, 3'b000);
    @(negedge clk);
    b_req = 3'b001;
    #1;
    check("inflt_gnt0", b_gnt, 3'b001);
    @(negedge clk);
    b_req = 3'b010;
    #1;
    check("inflt_gnt1", b_gnt, 3'b010);
    @(negedge clk);
    reset = 1'b1;
    b_req = 3'b011;
    #1;
    check("mid_rst_rvalid", b_rvalid, 3'b000);
    check("mid_rst_gnt", b_gnt, 3'b000);
    check("mid_rst_en", b_en, 0);
    @(negedge clk);
    reset = 1'b0;
    b_req = 3'b000;
    a_req = 3'b111;
    #1;
    check("post_rst_rvalid", b_rvalid, 3'b000);
    check("post_rst_a_gnt", a_gnt, 3'b001);
    @(negedge clk);
    a_req = 3'b000;
    #1;
    check("post_rst_rvalid2", b_rvalid, 3'b000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sp_sram_arbiter.md
Name: sp_sram_arbiter

Overview:
Parametrised N-channel arbiter that shares the single-port SP SRAM between several requesters, such as CTL instruction fetch, CTL data access and a DMA engine. Each cycle it grants one channel and drives the SRAM port from that channel. It routes read data back to the requester with a per-channel valid strobe. It supports round-robin or fixed priority, plus bounded bus locking for bursts.

Parameters:
NUM_CH, 2, number of requesting channels (2..8)
ADDR_W, 16, SRAM address width
DATA_W, 32, SRAM data width
RD_LAT, 1, SRAM read latency in cycles (1..4)
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)
MAX_LOCK, 8, maximum consecutive locked grants to one channel

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_CH  per-channel access request
we  in  NUM_CH  per-channel write enable (1 = write, 0 = read)
addr  in  NUM_CH*ADDR_W  per-channel address, channel i at bits [i*ADDR_W +: ADDR_W]
wdata  in  NUM_CH*DATA_W  per-channel write data, same packing as addr
lock  in  NUM_CH  keep the grant on the next cycle (burst)
gnt  out  NUM_CH  one-hot grant; access accepted when req[i] & gnt[i]
rvalid  out  NUM_CH  read data valid for channel i
rdata  out  DATA_W  read data, shared by all channels
sram_ADDR  out  ADDR_W  SRAM address
sram_DI  out  DATA_W  SRAM write data
sram_EN  out  1  SRAM enable
sram_WE  out  1  SRAM write enable
sram_DO  in  DATA_W  SRAM read data, valid RD_LAT cycles after the read cycle

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- While reset is high, all of the following hold:
  - gnt = 0, rvalid = 0, sram_EN = 0, sram_WE = 0, sram_ADDR = 0, sram_DI = 0.
  - The priority pointer is set so channel 0 is highest; the lock counter and lock owner are cleared.
  - The read-tracking pipeline is flushed, so reads in flight at reset never produce rvalid.
- gnt is combinational from req and registered state. At most one bit is set, and gnt is 0 when req is 0. Grant is combinational with zero latency: a request is accepted in the same cycle it is raised if it wins.
- SRAM drive:
  - sram_EN = |(req & gnt).
  - sram_WE, sram_ADDR and sram_DI are muxed from the granted channel.
  - All four are 0 when there is no grant.
- Round-robin (PRIO_MODE = 0):
  - Search order starts at last_winner+1 modulo NUM_CH.
  - last_winner updates only on an accepted access.
- Fixed priority (PRIO_MODE = 1): the lowest-index requesting channel wins.
- Lock:
  - If channel k is accepted with lock[k] = 1, then next cycle k wins whenever req[k] = 1, overriding the priority scheme.
  - If req[k] drops, the lock is released immediately.
  - lock_cnt counts consecutive locked grants. When it reaches MAX_LOCK, the lock is ignored for one arbitration: k is treated as last_winner and lock_cnt resets to 0.
  - Any unlocked grant also resets lock_cnt.
- Read return:
  - Each accepted read pushes {valid, channel id} into an RD_LAT-deep shift pipeline.
  - At the pipeline output, rvalid[id] = 1 for exactly one cycle, and rdata = sram_DO passed through combinationally.
  - Back-to-back reads sustain one per cycle.
- Writes produce no rvalid.
- Same-address accesses from different channels are ordered strictly by grant order. A read granted the cycle after a write returns the new data.
- A request with gnt = 0 must be held by the requester (req, we, addr and wdata stable) until granted. The arbiter does not check this.
- Dropping req while ungranted is legal and has no side effect.

Decomposition:
- Package sp_arb_pkg holds:
  - the PRIO_RR and PRIO_FIXED constants;
  - the function clog2 for the channel-id width;
  - the typedef of the read-pipeline entry {valid, ch_id}.
- One sub-module, sp_rr_picker: combinational rotate-priority one-hot picker taking req, start index and mode, and producing a one-hot winner. The arbiter top holds the state, lock logic and read pipeline.

Test Plan:
- Reset asserted mid-stream with 2 reads in flight (RD_LAT = 2) -> no rvalid in the following cycles; gnt = 0 and sram_EN = 0 during reset; channel 0 wins first after release.
- NUM_CH = 3, PRIO_MODE = 0, all req held high, reads at addrs 0x10/0x20/0x30 -> gnt cycles 001, 010, 100, 001; rvalid order ch0, ch1, ch2 with the matching SRAM data, each 1 cycle after its grant.
- PRIO_MODE = 1, ch0 and ch2 requesting continuously -> ch0 granted every cycle; ch2 granted only once ch0 drops req.
- ch1 write 0xDEADBEEF to 0x40 while ch0 reads 0x40 in the same cycle (RR pointer favouring ch1) -> ch1 granted first; ch0 granted next cycle and reads 0xDEADBEEF.
- MAX_LOCK = 4, ch0 with req and lock held, ch1 requesting -> ch0 granted 5 consecutive cycles (initial plus 4 locked), then ch1 granted once, then ch0 resumes.
- ch1 read accepted, then ch1 drops req during the RD_LAT wait -> rvalid[1] still pulses once with the correct data.
